video_timing_generator: RTL and testbench

//  Raster timing source for the DVI/VGA test path. Produces hs, vs, de and the active-pixel

---
 rtl/video_timing_generator_pkg.sv | 23 ++
 rtl/video_axis_counter.sv | 48 ++++
 rtl/video_timing_generator.sv | 86 ++++++++
 tb/tb_video_timing_generator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/video_timing_generator_pkg.sv
// Shared raster-timing definitions: axis phase encoding and SVGA 800x600@60 defaults.
// Future timing modes reuse these constants and the phase type.
package video_timing_defs;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } axisPhaseT;

  localparam int CNT_W = 11;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Used for both horizontal (advance every pixel) and vertical (advance on line wrap).
module video_axis_counter
  import video_timing_defs::*;
#(
  parameter int ACTIVE = SVGA_H_ACTIVE,
  parameter int FP     = SVGA_H_FP,
  parameter int SYNC   = SVGA_H_SYNC,
  parameter int BP     = SVGA_H_BP
) (
  input  logic             pixelClk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output axisPhaseT        phase,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // Last count value of each phase; the phase moves on once its final count is consumed.
  localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] END_BACK   = CNT_W'(TOTAL - 1);

  assign wrap = advance && (count == END_BACK);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge pixelClk) begin
    if (reset || clear) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else if (advance) begin
      count <= wrap ? '0 : count + 1'b1;
      unique case (phase)
        PH_ACTIVE: if (count == END_ACTIVE) phase <= PH_FRONT;
        PH_FRONT:  if (count == END_FRONT)  phase <= PH_SYNC;
        PH_SYNC:   if (count == END_SYNC)   phase <= PH_BACK;
        PH_BACK:   if (count == END_BACK)   phase <= PH_ACTIVE;
        default:                            phase <= PH_ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing source: two axis counters feed one register stage that produces
// polarised syncs, data enable, active-pixel coordinates and line/frame start pulses.
module video_timing_generator
  import video_timing_defs::*;
#(
  parameter int   H_ACTIVE = SVGA_H_ACTIVE,
  parameter int   H_FP     = SVGA_H_FP,
  parameter int   H_SYNC   = SVGA_H_SYNC,
  parameter int   H_BP     = SVGA_H_BP,
  parameter int   V_ACTIVE = SVGA_V_ACTIVE,
  parameter int   V_FP     = SVGA_V_FP,
  parameter int   V_SYNC   = SVGA_V_SYNC,
  parameter int   V_BP     = SVGA_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic       pixelClk,
  input  logic       reset,
  input  logic       enable,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic [9:0] pixelsX,
  output logic [9:0] pixelsY,
  output logic       lineStart,
  output logic       frameStart
);

  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  axisPhaseT        hPhase;
  axisPhaseT        vPhase;
  logic             hWrap;
  logic             vWrapUnused;
  logic             activeNow;
  logic             hOrigin;

  video_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) hAxis (
    .pixelClk(pixelClk),
    .reset   (reset),
    .clear   (~enable),
    .advance (enable),
    .count   (hCount),
    .phase   (hPhase),
    .wrap    (hWrap)
  );

  video_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) vAxis (
    .pixelClk(pixelClk),
    .reset   (reset),
    .clear   (~enable),
    .advance (enable && hWrap),
    .count   (vCount),
    .phase   (vPhase),
    .wrap    (vWrapUnused)
  );

  assign activeNow = (hPhase == PH_ACTIVE) && (vPhase == PH_ACTIVE);
  assign hOrigin   = activeNow && (hCount == '0);

  // Disabled timing looks exactly like reset: blanked, syncs idle, no pulses.
  always_ff @(posedge pixelClk) begin
    if (reset || !enable) begin
      hs         <= ~HS_POL;
      vs         <= ~VS_POL;
      de         <= 1'b0;
      pixelsX    <= '0;
      pixelsY    <= '0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      hs         <= (hPhase == PH_SYNC) ? HS_POL : ~HS_POL;
      vs         <= (vPhase == PH_SYNC) ? VS_POL : ~VS_POL;
      de         <= activeNow;
      pixelsX    <= activeNow ? hCount[9:0] : '0;
      pixelsY    <= activeNow ? vCount[9:0] : '0;
      lineStart  <= hOrigin;
      frameStart <= hOrigin && (vCount == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench: a default SVGA instance checks line timing, a small inverted-polarity
// instance checks frame wrap, vertical sync, enable drop and mid-line reset.
module tb_video_timing_generator;

  localparam int BH_A = 800, BH_F = 40, BH_S = 128, BH_B = 88;
  localparam int BH_T = BH_A + BH_F + BH_S + BH_B;
  localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_A = 4, SV_F = 1, SV_S = 2, SV_B = 1;
  localparam int SH_T = SH_A + SH_F + SH_S + SH_B;
  localparam int SV_T = SV_A + SV_F + SV_S + SV_B;

  logic       pixelClk = 1'b0;
  logic       reset;
  logic       bEnable, sEnable;
  logic       bHs, bVs, bDe, bLs, bFs;
  logic [9:0] bX, bY;
  logic       sHs, sVs, sDe, sLs, sFs;
  logic [9:0] sX, sY;

  int total = 0;
  int bad   = 0;

  always #5 pixelClk = ~pixelClk;

  video_timing_generator bigDut (
    .pixelClk(pixelClk), .reset(reset), .enable(bEnable),
    .hs(bHs), .vs(bVs), .de(bDe), .pixelsX(bX), .pixelsY(bY),
    .lineStart(bLs), .frameStart(bFs)
  );

  video_timing_generator #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) smallDut (
    .pixelClk(pixelClk), .reset(reset), .enable(sEnable),
    .hs(sHs), .vs(sVs), .de(sDe), .pixelsX(sX), .pixelsY(sY),
    .lineStart(sLs), .frameStart(sFs)
  );

  function automatic logic [24:0] pk(input logic d, input logic [9:0] x, input logic [9:0] y,
                                     input logic h, input logic v, input logic l, input logic f);
    return {d, x, y, h, v, l, f};
  endfunction

  // Expected outputs for counter position (h, v) one cycle earlier.
  function automatic logic [24:0] model(input int h, input int v, input int hA, input int hF,
                                        input int hS, input int vA, input int vF, input int vS,
                                        input logic hp, input logic vp);
    logic d, hsA, vsA;
    d   = (h < hA) && (v < vA);
    hsA = (h >= hA + hF) && (h < hA + hF + hS);
    vsA = (v >= vA + vF) && (v < vA + vF + vS);
    return pk(d, d ? 10'(h) : 10'd0, d ? 10'(v) : 10'd0, hsA ? hp : ~hp, vsA ? vp : ~vp,
              d && h == 0, d && h == 0 && v == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixelClk);
    #1;
  endtask

  function automatic logic [24:0] bObs();
    return pk(bDe, bX, bY, bHs, bVs, bLs, bFs);
  endfunction

  function automatic logic [24:0] sObs();
    return pk(sDe, sX, sY, sHs, sVs, sLs, sFs);
  endfunction

  initial begin
    int bh, bv, sh, sv;
    int hsLine1, deCount, lsCount, fsCount, lastLs;
    int sDeCnt, sVsCnt, sFsCnt, lastSFs, guard;

    reset   = 1'b1;
    bEnable = 1'b1;
    sEnable = 1'b1;
    repeat (4) tick();
    check("reset_big",   32'(bObs()), 32'(pk(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    check("reset_small", 32'(sObs()), 32'(pk(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0)));

    reset = 1'b0;
    bh = 0; bv = 0; sh = 0; sv = 0;
    hsLine1 = 0; deCount = 0; lsCount = 0; fsCount = 0; lastLs = 0;
    sDeCnt = 0; sVsCnt = 0; sFsCnt = 0; lastSFs = 0;
    for (int n = 1; n <= 3 * BH_T; n++) begin
      tick();
      check($sformatf("big_cyc%0d", n), 32'(bObs()),
            32'(model(bh, bv, BH_A, BH_F, BH_S, 600, 1, 4, 1'b1, 1'b1)));
      check($sformatf("small_cyc%0d", n), 32'(sObs()),
            32'(model(sh, sv, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, 1'b0, 1'b0)));
      if (n == 1) check("first_fs", 32'(bFs), 32'd1);
      if (n == 800) check("x799", 32'(bX), 32'd799);
      if (n == 801) check("de_off_801", 32'(bDe), 32'd0);
      if (n > BH_T && n <= 2 * BH_T && bHs) hsLine1++;
      if (bDe) deCount++;
      if (bFs) fsCount++;
      if (bLs) begin
        lsCount++;
        if (lastLs != 0) check("ls_period", 32'(n - lastLs), 32'(BH_T));
        lastLs = n;
      end
      if (n <= 3 * SH_T * SV_T) begin
        if (sDe) sDeCnt++;
        if (!sVs) sVsCnt++;
      end
      if (sFs) begin
        sFsCnt++;
        if (lastSFs != 0) check("small_fs_period", 32'(n - lastSFs), 32'(SH_T * SV_T));
        lastSFs = n;
      end
      bh++;
      if (bh == BH_T) begin bh = 0; bv++; end
      sh++;
      if (sh == SH_T) begin sh = 0; sv = (sv + 1) % SV_T; end
    end
    check("hs_per_line", 32'(hsLine1), 32'(BH_S));
    check("de_3lines",   32'(deCount), 32'(3 * BH_A));
    check("ls_count",    32'(lsCount), 32'd3);
    check("fs_count",    32'(fsCount), 32'd1);
    check("small_de_3frames", 32'(sDeCnt), 32'(3 * SH_A * SV_A));
    check("small_vs_3frames", 32'(sVsCnt), 32'(3 * SV_S * SH_T));
    check("small_fs_total",   32'(sFsCnt), 32'((3 * BH_T) / (SH_T * SV_T) + 1));

    // Walk the small instance to row 2 column 5, then drop enable.
    guard = 0;
    while (!(sh == 5 && sv == 2) && guard < 2 * SH_T * SV_T) begin
      tick();
      check("walk", 32'(sObs()), 32'(model(sh, sv, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, 1'b0, 1'b0)));
      sh++;
      if (sh == SH_T) begin sh = 0; sv = (sv + 1) % SV_T; end
      guard++;
    end
    check("walk_reached", 32'(sh == 5 && sv == 2), 32'd1);

    sEnable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("en_low%0d", i), 32'(sObs()),
            32'(pk(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0)));
    end
    sEnable = 1'b1;
    tick();
    check("reenable_origin", 32'(sObs()), 32'(pk(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1)));
    sh = 1; sv = 0;
    for (int i = 0; i < 2 * SH_T + 5; i++) begin
      tick();
      check($sformatf("after_en%0d", i), 32'(sObs()),
            32'(model(sh, sv, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, 1'b0, 1'b0)));
      sh++;
      if (sh == SH_T) begin sh = 0; sv = (sv + 1) % SV_T; end
    end

    // Mid-line reset with enable held high.
    reset = 1'b1;
    tick();
    check("midreset_small", 32'(sObs()), 32'(pk(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0)));
    check("midreset_big",   32'(bObs()), 32'(pk(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    reset = 1'b0;
    tick();
    check("postreset_small", 32'(sObs()), 32'(pk(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1)));
    check("postreset_big",   32'(bObs()), 32'(pk(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1)));
    sh = 1; sv = 0;
    for (int i = 0; i < SH_T * SV_T + 2; i++) begin
      tick();
      check($sformatf("postreset%0d", i), 32'(sObs()),
            32'(model(sh, sv, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, 1'b0, 1'b0)));
      sh++;
      if (sh == SH_T) begin sh = 0; sv = (sv + 1) % SV_T; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
